taint_sink_checker: RTL and testbench

- Sink-side checker for the taint-tracking flow. Stimulus benches inject value/taint-label pairs into the instrumented logic; this block sits at the output end and receives them.
- Samples a data/taint pair from an instrumented DUT output each valid cycle.
- Accumulates which taint labels reached the sink and counts tainted samples.
- Flags a sticky violation when a label outside the allowed mask arrives, and records when it first happened.

---
 rtl/taint_sink_checker.sv | 142 ++++++++++++++
 tb/tb_taint_sink_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/taint_sink_checker.sv
// taint_sink_checker: sink-side monitor for the taint-tracking flow.
// Collects every taint label that reaches the sink, counts tainted samples,
// and latches the first sample whose labels fall outside ALLOWED_MASK.
// Optional macro TAINT_SINK_X_CHECK_EN: compiles in a sticky X/Z detector on d.
module taint_sink_checker #(
    parameter int                 DATA_W       = 1,
    parameter int                 TAINT_W      = 32,
    parameter int                 CNT_W        = 16,
    parameter logic [TAINT_W-1:0] ALLOWED_MASK = {{(TAINT_W-1){1'b0}}, 1'b1}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  d,
    input  logic [TAINT_W-1:0] d_t,
    input  logic               clear_i,
    output logic [TAINT_W-1:0] seen_t,
    output logic               violation,
    output logic [TAINT_W-1:0] viol_label,
    output logic [CNT_W-1:0]   viol_cycle,
    output logic [CNT_W-1:0]   taint_cnt,
    output logic [CNT_W-1:0]   cyc_cnt,
    output logic [1:0]         state,
    output logic               x_seen
);

    typedef enum logic [1:0] {
        CLEAN    = 2'd0,
        TAINTED  = 2'd1,
        VIOLATED = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TAINT_W-1:0] bad_t;
    logic               sample_taint;
    logic               sample_bad;
    logic               first_viol;

    assign bad_t        = d_t & ~ALLOWED_MASK;
    assign sample_taint = valid_i && (d_t != '0);
    assign sample_bad   = valid_i && (bad_t != '0);
    // Only the transition into VIOLATED captures the label/cycle.
    assign first_viol   = !clear_i && sample_bad && (state_q != VIOLATED);
    assign state        = state_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: clear wins, VIOLATED absorbs, disallowed label beats plain taint
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = CLEAN;
        end else begin
            case (state_q)
                CLEAN: begin
                    if (sample_bad) begin
                        state_d = VIOLATED;
                    end else if (sample_taint) begin
                        state_d = TAINTED;
                    end
                end
                TAINTED: begin
                    if (sample_bad) begin
                        state_d = VIOLATED;
                    end
                end
                VIOLATED: state_d = VIOLATED;
                default:  state_d = CLEAN;
            endcase
        end
    end

    // Free-running saturating cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (clear_i) begin
            cyc_cnt <= '0;
        end else if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    // Label accumulation and saturating tainted-sample count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_t    <= '0;
            taint_cnt <= '0;
        end else if (clear_i) begin
            seen_t    <= '0;
            taint_cnt <= '0;
        end else if (valid_i) begin
            seen_t <= seen_t | d_t;
            if (sample_taint && (taint_cnt != '1)) begin
                taint_cnt <= taint_cnt + 1'b1;
            end
        end
    end

    // First-violation capture; viol_cycle takes the pre-increment cycle count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            violation  <= 1'b0;
            viol_label <= '0;
            viol_cycle <= '0;
        end else if (clear_i) begin
            violation  <= 1'b0;
            viol_label <= '0;
            viol_cycle <= '0;
        end else if (first_viol) begin
            violation  <= 1'b1;
            viol_label <= bad_t;
            viol_cycle <= cyc_cnt;
        end
    end

`ifdef TAINT_SINK_X_CHECK_EN
    // Sticky X/Z detector on sampled data (simulation aid, independent of the FSM)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_seen <= 1'b0;
        end else if (clear_i) begin
            x_seen <= 1'b0;
        end else if (valid_i && ((^d) === 1'bx)) begin
            x_seen <= 1'b1;
        end
    end
`else
    logic unused_d;
    assign unused_d = ^d;
    assign x_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_taint_sink_checker.sv
// Bench for taint_sink_checker: directed steps plus random traffic, checked
// against an abstract model (label set, raw counts, first-violation record).
// Two instances share the stimulus: default CNT_W=16 and CNT_W=4 for saturation.
module tb_taint_sink_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [0:0]  d = 1'b0;
    logic [31:0] d_t = '0;
    logic        clear_i = 1'b0;

    logic [31:0] a_seen, a_vlab, b_seen, b_vlab;
    logic        a_viol, a_x, b_viol, b_x;
    logic [15:0] a_vcyc, a_tcnt, a_cyc;
    logic [3:0]  b_vcyc, b_tcnt, b_cyc;
    logic [1:0]  a_state, b_state;

    int total = 0;
    int bad = 0;

    // abstract model
    logic [31:0] m_seen;
    bit          m_viol;
    logic [31:0] m_vlab;
    int          m_vcyc;
    int          m_tcnt;
    int          m_cyc;
    bit          m_x;

    always #5 clk = ~clk;

    taint_sink_checker #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .d(d), .d_t(d_t), .clear_i(clear_i),
        .seen_t(a_seen), .violation(a_viol), .viol_label(a_vlab), .viol_cycle(a_vcyc),
        .taint_cnt(a_tcnt), .cyc_cnt(a_cyc), .state(a_state), .x_seen(a_x)
    );

    taint_sink_checker #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .d(d), .d_t(d_t), .clear_i(clear_i),
        .seen_t(b_seen), .violation(b_viol), .viol_label(b_vlab), .viol_cycle(b_vcyc),
        .taint_cnt(b_tcnt), .cyc_cnt(b_cyc), .state(b_state), .x_seen(b_x)
    );

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = '0; m_viol = 0; m_vlab = '0; m_vcyc = 0;
        m_tcnt = 0; m_cyc = 0; m_x = 0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] dt, input bit clr, input logic [0:0] dd);
        if (clr) begin
            model_reset();
        end else begin
            if (v) begin
                m_seen |= dt;
                if (dt != 0) m_tcnt++;
                if (((dt & ~32'h1) != 0) && !m_viol) begin
                    m_viol = 1;
                    m_vlab = dt & ~32'h1;
                    m_vcyc = m_cyc;
                end
`ifdef TAINT_SINK_X_CHECK_EN
                if ((^dd) === 1'bx) m_x = 1;
`endif
            end
            m_cyc++;
        end
    endtask

    task automatic check_all();
        logic [1:0] es;
        es = m_viol ? 2'd2 : ((m_seen != 0) ? 2'd1 : 2'd0);
        chk("a_seen_t", a_seen, m_seen);
        chk("a_violation", a_viol, m_viol);
        chk("a_viol_label", a_vlab, m_vlab);
        chk("a_viol_cycle", a_vcyc, sat(m_vcyc, 65535));
        chk("a_taint_cnt", a_tcnt, sat(m_tcnt, 65535));
        chk("a_cyc_cnt", a_cyc, sat(m_cyc, 65535));
        chk("a_state", a_state, es);
        chk("a_x_seen", a_x, m_x);
        chk("b_seen_t", b_seen, m_seen);
        chk("b_violation", b_viol, m_viol);
        chk("b_viol_label", b_vlab, m_vlab);
        chk("b_viol_cycle", b_vcyc, sat(m_vcyc, 15));
        chk("b_taint_cnt", b_tcnt, sat(m_tcnt, 15));
        chk("b_cyc_cnt", b_cyc, sat(m_cyc, 15));
        chk("b_state", b_state, es);
        chk("b_x_seen", b_x, m_x);
    endtask

    task automatic step(input bit v, input logic [31:0] dt, input bit clr, input logic [0:0] dd);
        valid_i = v; d_t = dt; clear_i = clr; d = dd;
        @(posedge clk);
        model_edge(v, dt, clr, dd);
        #1;
        check_all();
    endtask

    // asynchronous reset pulse, checked before any clock edge arrives
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        valid_i = 1'b0; clear_i = 1'b0; d_t = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(0, '0, 0, 1'b0);
        #1;
    endtask

    initial begin
        logic [31:0] dt;
        int sel;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(0, '0, 0, 1'b0);
        #1;

        // single allowed label
        step(0, '0, 0, 1'b0);
        step(1, 32'h1, 0, 1'b1);
        chk("plan_tainted_state", a_state, 2'd1);
        chk("plan_tainted_cnt", a_tcnt, 16'd1);

        // disallowed label -> violation, then later violation leaves capture alone
        step(1, 32'h2, 0, 1'b0);
        chk("plan_viol_state", a_state, 2'd2);
        chk("plan_viol_label", a_vlab, 32'h2);
        step(1, 32'h4, 0, 1'b0);
        chk("plan_viol_label_kept", a_vlab, 32'h2);
        chk("plan_seen_7", a_seen, 32'h7);

        // zero label counts nothing, idle cycle changes nothing but cyc
        step(1, 32'h0, 0, 1'b1);
        step(0, 32'h8, 0, 1'b0);

        // clear beats valid in the same cycle
        step(1, 32'h2, 1, 1'b0);
        chk("plan_clear_state", a_state, 2'd0);
        chk("plan_clear_viol", a_viol, 1'b0);

        // saturation on the narrow instance
        for (int i = 0; i < 20; i++) step(1, 32'h1, 0, 1'b0);
        chk("plan_b_tcnt_sat", b_tcnt, 4'hf);
        chk("plan_b_cyc_sat", b_cyc, 4'hf);

        async_reset();
        check_all();

`ifdef TAINT_SINK_X_CHECK_EN
        step(1, 32'h0, 0, 1'bx);
        chk("plan_x_seen", a_x, 1'b1);
        step(0, 32'h0, 1, 1'b0);
`else
        step(1, 32'h0, 0, 1'b1);
        chk("plan_x_off", a_x, 1'b0);
`endif

        // random traffic with occasional clears and one mid-run reset
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: dt = 32'h0;
                1, 2: dt = 32'h1;
                3: dt = 32'h1 << $urandom_range(0, 31);
                default: dt = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0 && sel != 1) dt = 32'h1;
            step(($urandom_range(0, 3) != 0), dt, ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)));
            if (n == 200) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop in case something stalls
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
